sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 186 ++++++++++++++++++
 tb/tb_sram_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Wishbone classic slave driving an asynchronous SRAM with a fixed-sequence FSM.
// Every SRAM strobe and Wishbone output comes straight from a flop.
// Optional macro SRAM_EXTRA_WAIT_EN lengthens the read sample point and the
// write-enable pulse by one cycle each, for slower SRAM parts.
//
// Handshake: a request is taken only in IDLE when wb_cyc_i & wb_stb_i are high.
// The master holds the request until it sees wb_ack_o. wb_ack_o is high for
// exactly one cycle, in DONE. If wb_cyc_i drops while a transfer is in flight,
// the SRAM access still finishes, but no ack is given.
module sram_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int SRAM_DATA_WIDTH = 32,
    localparam int SRAM_BYTES     = SRAM_DATA_WIDTH / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    output logic                       wb_ack_o,
    input  logic [ADDR_WIDTH-1:0]      wb_adr_i,
    input  logic [DATA_WIDTH-1:0]      wb_dat_i,
    output logic [DATA_WIDTH-1:0]      wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]    wb_sel_i,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [SRAM_DATA_WIDTH-1:0] sram_data,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [SRAM_BYTES-1:0]      sram_be_n,
    output logic [2:0]                 dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        READ_2  = 3'd2,
        WRITE   = 3'd3,
        WRITE_2 = 3'd4,
        WRITE_3 = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                      state_q;
    logic                        ack_q;
    logic [DATA_WIDTH-1:0]       rdat_q;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q;
    logic                        ce_n_q;
    logic                        oe_n_q;
    logic                        we_n_q;
    logic [SRAM_BYTES-1:0]       be_n_q;
    logic [SRAM_DATA_WIDTH-1:0]  wdat_q;
    logic                        drive_q;
    logic                        cyc_lost_q;
`ifdef SRAM_EXTRA_WAIT_EN
    logic                        wait_q;
`endif

    // The byte offset and the address bits above the SRAM range are not used.
    // Higher addresses simply wrap onto the SRAM.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

    // Drive the data bus only while the write data is latched and wanted.
    assign sram_data   = drive_q ? wdat_q : {SRAM_DATA_WIDTH{1'bz}};

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = rdat_q;
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;
    assign dbg_state_o = state_q;

    // Transfer sequencer: state plus every registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            addr_q     <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
            wdat_q     <= '0;
            drive_q    <= 1'b0;
            cyc_lost_q <= 1'b0;
`ifdef SRAM_EXTRA_WAIT_EN
            wait_q     <= 1'b0;
`endif
        end else begin
            // Remember a dropped cycle so that DONE can suppress the ack.
            if (state_q != IDLE && state_q != DONE && !wb_cyc_i) begin
                cyc_lost_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        addr_q     <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                        be_n_q     <= ~wb_sel_i;
                        ce_n_q     <= 1'b0;
                        cyc_lost_q <= 1'b0;
`ifdef SRAM_EXTRA_WAIT_EN
                        wait_q     <= 1'b0;
`endif
                        if (wb_we_i) begin
                            wdat_q  <= wb_dat_i;
                            drive_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            oe_n_q  <= 1'b0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
`ifdef SRAM_EXTRA_WAIT_EN
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        wait_q  <= 1'b0;
                        state_q <= READ_2;
                    end
`else
                    state_q <= READ_2;
`endif
                end
                READ_2: begin
                    rdat_q  <= sram_data;
                    ack_q   <= wb_cyc_i && !cyc_lost_q;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    be_n_q  <= '1;
                    state_q <= DONE;
                end
                WRITE: begin
                    we_n_q  <= 1'b0;
                    state_q <= WRITE_2;
                end
                WRITE_2: begin
`ifdef SRAM_EXTRA_WAIT_EN
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        wait_q  <= 1'b0;
                        we_n_q  <= 1'b1;
                        state_q <= WRITE_3;
                    end
`else
                    we_n_q  <= 1'b1;
                    state_q <= WRITE_3;
`endif
                end
                WRITE_3: begin
                    drive_q <= 1'b0;
                    ack_q   <= wb_cyc_i && !cyc_lost_q;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    be_n_q  <= '1;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    drive_q <= 1'b0;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    be_n_q  <= '1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller. It contains an SRAM device model and a word-array
// reference memory. The expected latencies depend on whether the
// SRAM_EXTRA_WAIT_EN macro is defined.
module tb_sram_controller;

`ifdef SRAM_EXTRA_WAIT_EN
    localparam int RD_LAT = 5;
    localparam int WR_LAT = 6;
    localparam int WE_LOW = 2;
    localparam int OE_LOW = 3;
`else
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 5;
    localparam int WE_LOW = 1;
    localparam int OE_LOW = 2;
`endif

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic        ack;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        ce_n, oe_n, we_n;
    logic [3:0]  be_n;
    logic [2:0]  dbg_state;

    sram_controller dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_ack_o   (ack),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_i),
        .wb_dat_o   (dat_o),
        .wb_sel_i   (sel),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_ce_n  (ce_n),
        .sram_oe_n  (oe_n),
        .sram_we_n  (we_n),
        .sram_be_n  (be_n),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM device. It covers the low 256 words. It drives the bus
    // while selected and output-enabled, and stores the enabled bytes while
    // write-enabled.
    logic [31:0] sram_mem [0:255];
    logic [31:0] sram_rd;
    assign sram_rd   = sram_mem[sram_addr[7:0]];
    assign sram_data = (!ce_n && !oe_n) ? sram_rd : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
            end
        end
    end

    // reference memory and counters
    logic [31:0] ref_mem [0:255];
    int n_vec = 0;
    int n_err = 0;

    // per-transaction observations
    int          obs_lat, obs_we_lo, obs_oe_lo, obs_overlap;
    logic [19:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdat, obs_rdat;
    logic [6:0]  obs_strobes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a >> 2) & 32'h000F_FFFF;
    endfunction

    // driver: one Wishbone request, observed cycle by cycle at the falling edge
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int drop_at);
        @(negedge clk);
        chk("idle_ack_low", {31'd0, ack}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        obs_lat = 0; obs_we_lo = 0; obs_oe_lo = 0; obs_overlap = 0;
        obs_addr = 'x; obs_be = 'x; obs_wdat = 'x; obs_rdat = 'x; obs_strobes = 'x;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (!we_n) begin obs_we_lo++; obs_wdat = sram_data; end
            if (!oe_n) obs_oe_lo++;
            if (!we_n && !oe_n) obs_overlap++;
            if (!ce_n) begin obs_addr = sram_addr; obs_be = be_n; end
            if (ack) begin
                obs_lat = c;
                obs_rdat = dat_o;
                obs_strobes = {ce_n, oe_n, we_n, be_n};
                break;
            end
            if (drop_at != 0 && c == drop_at) begin cyc = 1'b0; stb = 1'b0; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int drop_at);
        int i;
        i = idx_of(a);
        xfer(1'b1, a, d, s, drop_at);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
        end
        chk({tag, "_lat"}, obs_lat, (drop_at != 0) ? 0 : WR_LAT);
        chk({tag, "_we_low"}, obs_we_lo, WE_LOW);
        chk({tag, "_oe_low"}, obs_oe_lo, 0);
        chk({tag, "_overlap"}, obs_overlap, 0);
        chk({tag, "_addr"}, {12'd0, obs_addr}, word_of(a));
        chk({tag, "_be_n"}, {28'd0, obs_be}, {28'd0, ~s});
        chk({tag, "_bus"}, obs_wdat, d);
        if (drop_at == 0) chk({tag, "_done_strobes"}, {25'd0, obs_strobes}, 32'h7F);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [3:0] s,
                           input int drop_at);
        xfer(1'b0, a, 32'h0, s, drop_at);
        chk({tag, "_lat"}, obs_lat, (drop_at != 0) ? 0 : RD_LAT);
        chk({tag, "_oe_low"}, obs_oe_lo, OE_LOW);
        chk({tag, "_we_low"}, obs_we_lo, 0);
        chk({tag, "_overlap"}, obs_overlap, 0);
        chk({tag, "_addr"}, {12'd0, obs_addr}, word_of(a));
        chk({tag, "_be_n"}, {28'd0, obs_be}, {28'd0, ~s});
        if (drop_at == 0) begin
            chk({tag, "_data"}, obs_rdat, ref_mem[idx_of(a)]);
            chk({tag, "_done_strobes"}, {25'd0, obs_strobes}, 32'h7F);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
        chk({tag, "_dat_o"}, dat_o, 32'd0);
        chk({tag, "_addr"}, {12'd0, sram_addr}, 32'd0);
        chk({tag, "_strobes"}, {25'd0, ce_n, oe_n, we_n, be_n}, 32'h7F);
    endtask

    // safety net against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // directed sequence followed by randomized traffic
    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [31:0] upper;
        int          word;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'd0;
            ref_mem[i]  = 32'd0;
        end
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat_i = 32'd0; sel = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // word write, then word read of the same location
        do_write("wr_word", 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0);
        do_read("rd_word", 32'h0000_0010, 4'b1111, 0);
        chk("rd_word_const", obs_rdat, 32'hDEAD_BEEF);

        // single-byte write with an unaligned address; byte lanes come from sel only
        do_write("wr_byte", 32'h0000_0013, 32'hAB00_0000, 4'b1000, 0);
        do_read("rd_byte", 32'h0000_0010, 4'b1111, 0);
        chk("rd_byte_const", obs_rdat, 32'hABAD_BEEF);

        // back-to-back write then read at a wrapping address
        do_write("b2b_wr", 32'h0040_0008, 32'h1357_9BDF, 4'b1111, 0);
        do_read("b2b_rd", 32'h0040_0008, 4'b1111, 0);
        chk("b2b_addr_const", {12'd0, obs_addr}, 32'h0000_0002);

        // sel of zero still runs a full cycle and leaves memory untouched
        do_write("sel0_wr", 32'h0000_0010, 32'h5555_5555, 4'b0000, 0);
        do_read("sel0_rd", 32'h0000_0010, 4'b0000, 0);

        // cycle dropped mid-transfer: the access completes, but no ack is given
        do_write("drop_wr", 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 3);
        do_read("drop_rd", 32'h0000_0020, 4'b1111, 2);
        do_read("after_drop_rd", 32'h0000_0020, 4'b1111, 0);

        // reset pulsed during the write-enable phase
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0140; dat_i = 32'h1234_5678; sel = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_we_n", {31'd0, we_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("mid_reset_no_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        do_read("post_rst_rd", 32'h0000_0010, 4'b1111, 0);
        do_read("aborted_wr_rd", 32'h0000_0140, 4'b1111, 0);

        // randomized traffic with wrapping upper address bits and random idle gaps
        for (int t = 0; t < 40; t++) begin
            word  = int'($urandom_range(0, 255));
            upper = $urandom_range(0, 1023);
            a = (upper << 22) | (32'(word) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write("rnd_wr", a, d, s, 0);
            else                           do_read("rnd_rd", a, s, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
